pipe_ctrl: RTL and testbench

- Responder side of the decode-stage stall/exception interface. Collects stall requests from IF/ID/EXE/MEM and the exception code travelling down the pipe, and issues per-stage stall enables, pipeline flush and PC redirect.
- Owns the exception-entry/ERET sequencing FSM, including instruction-bus drain before redirect, and a stall-cycle performance counter.
- Sits beside the five-stage pipeline; feeds PC/IF/ID/EXE/MEM/WB pipeline registers and CP0.

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/pipe_ctrl_stall_prio_enc.sv | 27 ++
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/exception controller.
// Holds exception codes, stall vectors and FSM state encodings.
package pipe_ctrl_pkg;

    localparam int EXC_CODE_W = 5;
    typedef logic [EXC_CODE_W-1:0] exc_code_t;

    localparam exc_code_t EXC_INT   = 5'h00;
    localparam exc_code_t EXC_SYS   = 5'h08;
    localparam exc_code_t EXC_BREAK = 5'h09;
    localparam exc_code_t EXC_RI    = 5'h0a;
    localparam exc_code_t EXC_OV    = 5'h0c;
    localparam exc_code_t EXC_ERET  = 5'h0e;
    localparam exc_code_t EXC_NONE  = 5'h10;

    // Stall vectors are {wb, mem, exe, id, if, pc}; a stage stall freezes all upstream stages.
    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_IF    = 6'b000011;
    localparam logic [5:0] STALL_ID    = 6'b000111;
    localparam logic [5:0] STALL_EXE   = 6'b001111;
    localparam logic [5:0] STALL_MEM   = 6'b011111;
    localparam logic [5:0] STALL_DRAIN = STALL_IF;

    localparam logic PIPELINE_STOP   = 1'b1;
    localparam logic PIPELINE_NOSTOP = 1'b0;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
    localparam int          DRAIN_MAX_DEFAULT  = 15;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The EPC of a delay-slot instruction points back at its branch.
    function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic in_delay);
        return in_delay ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Combinational priority encoder from per-stage stall requests to the
// stall-enable vector; the most downstream requester wins.
module stall_prio_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       req_if,
    input  logic       req_id,
    input  logic       req_exe,
    input  logic       req_mem,
    output logic [5:0] stall
);

    // NOTE: assign a default first in always_comb so no path leaves the output unassigned (latch).
    always_comb begin
        stall = STALL_NONE;
        if (req_mem == PIPELINE_STOP) begin
            stall = STALL_MEM;
        end else if (req_exe == PIPELINE_STOP) begin
            stall = STALL_EXE;
        end else if (req_id == PIPELINE_STOP) begin
            stall = STALL_ID;
        end else if (req_if == PIPELINE_STOP) begin
            stall = STALL_IF;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Decode-side stall/exception controller: stall enables, flush, PC redirect,
// exception entry/ERET sequencing with ibus drain, and a stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          DRAIN_MAX  = DRAIN_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_exe,
    input  logic        stallreq_mem,
    input  logic [4:0]  mem_exccode,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay,
    input  logic [31:0] cp0_epc,
    input  logic        ibus_idle,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic        drain_timeout,
    output logic [31:0] stall_cycles
);

    localparam logic [3:0] DRAIN_LIMIT = 4'(DRAIN_MAX);

    state_t     state;
    logic [3:0] drain_cnt;
    logic [3:0] drain_cnt_inc;
    logic       drain_cnt_hit;
    logic       exc_accept;
    logic [5:0] run_stall;

    stall_prio_enc u_prio_enc (
        .req_if  (stallreq_if),
        .req_id  (stallreq_id),
        .req_exe (stallreq_exe),
        .req_mem (stallreq_mem),
        .stall   (run_stall)
    );

    // drain_cnt_inc is the number of drain cycles elapsed including the current one.
    assign drain_cnt_inc = drain_cnt + 4'd1;
    assign drain_cnt_hit = (drain_cnt_inc == DRAIN_LIMIT);

    // A pending exception waits while MEM is held; the held code stays visible.
    assign exc_accept = (state == ST_RUN) && (mem_exccode != EXC_NONE) && !stallreq_mem;

    // The redirect pulse depends on same-cycle ibus_idle, so it is decoded from state.
    always_comb begin
        stall          = STALL_NONE;
        redirect_valid = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_RUN:   stall = run_stall;
                ST_FLUSH: redirect_valid = ibus_idle;
                ST_DRAIN: begin
                    stall          = STALL_DRAIN;
                    redirect_valid = ibus_idle || drain_cnt_hit;
                end
                default:  stall = STALL_NONE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            drain_cnt     <= 4'd0;
            flush         <= 1'b0;
            exc_valid     <= 1'b0;
            drain_timeout <= 1'b0;
            redirect_pc   <= 32'd0;
            exc_epc       <= 32'd0;
            exc_code      <= EXC_NONE;
            exc_bd        <= 1'b0;
            stall_cycles  <= 32'd0;
        end else begin
            flush     <= 1'b0;
            exc_valid <= 1'b0;

            if ((stall != STALL_NONE) && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end

            unique case (state)
                ST_RUN: begin
                    if (exc_accept) begin
                        exc_code    <= mem_exccode;
                        exc_bd      <= mem_in_delay;
                        exc_epc     <= calc_epc(mem_pc, mem_in_delay);
                        redirect_pc <= (mem_exccode == EXC_ERET) ? cp0_epc : EXC_VECTOR;
                        flush       <= 1'b1;
                        exc_valid   <= (mem_exccode != EXC_ERET);
                        state       <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    drain_cnt <= 4'd0;
                    state     <= ibus_idle ? ST_RUN : ST_DRAIN;
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt_inc;
                    if (ibus_idle || drain_cnt_hit) begin
                        state <= ST_RUN;
                    end
                    if (!ibus_idle && drain_cnt_hit) begin
                        drain_timeout <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven stall encoding vectors plus
// directed exception, ERET, MEM-hold, drain, timeout and mid-drain reset sequences.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_exe, stallreq_mem;
    logic [4:0]  mem_exccode;
    logic [31:0] mem_pc;
    logic        mem_in_delay;
    logic [31:0] cp0_epc;
    logic        ibus_idle;
    logic [5:0]  stall;
    logic        flush, redirect_valid, exc_valid, exc_bd, drain_timeout;
    logic [31:0] redirect_pc, exc_epc, stall_cycles;
    logic [4:0]  exc_code;

    int         checks     = 0;
    int         failures   = 0;
    int         exp_cycles = 0;
    logic [5:0] exp_stall  = 6'd0;

    typedef struct {
        logic       r_if;
        logic       r_id;
        logic       r_exe;
        logic       r_mem;
        logic [5:0] exp_stall;
    } vec_t;

    vec_t vecs[10];

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_exe   (stallreq_exe),
        .stallreq_mem   (stallreq_mem),
        .mem_exccode    (mem_exccode),
        .mem_pc         (mem_pc),
        .mem_in_delay   (mem_in_delay),
        .cp0_epc        (cp0_epc),
        .ibus_idle      (ibus_idle),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_epc        (exc_epc),
        .exc_bd         (exc_bd),
        .drain_timeout  (drain_timeout),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic r_if, input logic r_id, input logic r_exe, input logic r_mem);
        stallreq_if  = r_if;
        stallreq_id  = r_id;
        stallreq_exe = r_exe;
        stallreq_mem = r_mem;
    endtask

    // Let combinational outputs settle, then check stall against the expected vector.
    task automatic settle_stall(input string name, input logic [5:0] es);
        #1;
        exp_stall = es;
        check(name, 32'(stall), 32'(es));
    endtask

    // Advance one clock; the stall-cycle model follows the stall expected this cycle.
    task automatic tick();
        @(posedge clk);
        if (rst) exp_cycles = 0;
        else if (exp_stall != 6'd0) exp_cycles++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011111};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001111};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b001111};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b011111};

        // Reset with requests active: stall must be forced to zero.
        rst = 1'b1;
        set_req(1'b1, 1'b1, 1'b1, 1'b1);
        mem_exccode  = EXC_NONE;
        mem_pc       = 32'd0;
        mem_in_delay = 1'b0;
        cp0_epc      = 32'd0;
        ibus_idle    = 1'b1;
        settle_stall("rst_stall", 6'd0);
        tick();
        tick();
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        settle_stall("reset_stall", 6'd0);
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset_exc_valid", 32'(exc_valid), 32'd0);
        check("reset_exc_code", 32'(exc_code), 32'(EXC_NONE));
        check("reset_stall_cycles", stall_cycles, 32'd0);

        // Stall priority vectors in RUN.
        for (int i = 0; i < 10; i++) begin
            set_req(vecs[i].r_if, vecs[i].r_id, vecs[i].r_exe, vecs[i].r_mem);
            settle_stall("vec_stall", vecs[i].exp_stall);
            tick();
            check("vec_stall_cycles", stall_cycles, 32'(exp_cycles));
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0);

        // SYSCALL in a delay slot with the ibus idle: flush and redirect together.
        mem_exccode  = EXC_SYS;
        mem_pc       = 32'h80001000;
        mem_in_delay = 1'b1;
        cp0_epc      = 32'h12345678;
        ibus_idle    = 1'b1;
        settle_stall("sys_t0_stall", 6'd0);
        check("sys_t0_flush", 32'(flush), 32'd0);
        tick();
        mem_exccode  = EXC_NONE;
        mem_in_delay = 1'b0;
        settle_stall("sys_t1_stall", 6'd0);
        check("sys_flush", 32'(flush), 32'd1);
        check("sys_exc_valid", 32'(exc_valid), 32'd1);
        check("sys_exc_epc", exc_epc, 32'h80000FFC);
        check("sys_exc_bd", 32'(exc_bd), 32'd1);
        check("sys_exc_code", 32'(exc_code), 32'(EXC_SYS));
        check("sys_redirect_pc", redirect_pc, 32'hBFC00380);
        check("sys_redirect_valid", 32'(redirect_valid), 32'd1);
        tick();

        // First RUN cycle after the flush: pulses drop and an ERET is accepted at once.
        mem_exccode = EXC_ERET;
        mem_pc      = 32'h80003000;
        cp0_epc     = 32'h80002000;
        settle_stall("b2b_stall", 6'd0);
        check("sys_flush_pulse", 32'(flush), 32'd0);
        check("sys_exc_valid_pulse", 32'(exc_valid), 32'd0);
        check("sys_redirect_pulse", 32'(redirect_valid), 32'd0);
        tick();
        mem_exccode = EXC_NONE;
        settle_stall("eret_stall", 6'd0);
        check("eret_flush", 32'(flush), 32'd1);
        check("eret_exc_valid", 32'(exc_valid), 32'd0);
        check("eret_redirect_pc", redirect_pc, 32'h80002000);
        check("eret_redirect_valid", 32'(redirect_valid), 32'd1);
        check("eret_exc_epc", exc_epc, 32'h80003000);
        check("eret_exc_bd", 32'(exc_bd), 32'd0);
        tick();
        settle_stall("eret_after_stall", 6'd0);
        check("eret_flush_pulse", 32'(flush), 32'd0);
        check("eret_redirect_pulse", 32'(redirect_valid), 32'd0);

        // BREAK held behind a data-bus wait for three cycles.
        mem_exccode = EXC_BREAK;
        mem_pc      = 32'h80004000;
        for (int k = 0; k < 3; k++) begin
            set_req(1'b0, 1'b0, 1'b0, 1'b1);
            settle_stall("memhold_stall", 6'b011111);
            check("memhold_flush", 32'(flush), 32'd0);
            tick();
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        settle_stall("memrel_stall", 6'd0);
        check("memrel_flush", 32'(flush), 32'd0);
        tick();
        mem_exccode = EXC_NONE;
        settle_stall("memexc_stall", 6'd0);
        check("memexc_flush", 32'(flush), 32'd1);
        check("memexc_exc_valid", 32'(exc_valid), 32'd1);
        check("memexc_exc_code", 32'(exc_code), 32'(EXC_BREAK));
        tick();

        // RI with the ibus busy: FLUSH, three drain cycles, redirect on first idle cycle.
        mem_exccode = EXC_RI;
        mem_pc      = 32'h80005000;
        ibus_idle   = 1'b0;
        settle_stall("drain_t0_stall", 6'd0);
        tick();
        mem_exccode = EXC_NONE;
        set_req(1'b1, 1'b1, 1'b0, 1'b0);
        settle_stall("drain_flush_stall", 6'd0);
        check("drain_flush", 32'(flush), 32'd1);
        check("drain_flush_redirect", 32'(redirect_valid), 32'd0);
        tick();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            stallreq_id = (k == 1);
            mem_exccode = (k == 2) ? EXC_OV : EXC_NONE;
            settle_stall("drain_stall", 6'b000011);
            check("drain_redirect_low", 32'(redirect_valid), 32'd0);
            check("drain_flush_low", 32'(flush), 32'd0);
            tick();
        end
        stallreq_id = 1'b0;
        mem_exccode = EXC_NONE;
        ibus_idle   = 1'b1;
        settle_stall("drain_exit_stall", 6'b000011);
        check("drain_redirect", 32'(redirect_valid), 32'd1);
        check("drain_redirect_pc", redirect_pc, 32'hBFC00380);
        check("drain_no_new_exc", 32'(exc_code), 32'(EXC_RI));
        tick();
        settle_stall("drain_run_stall", 6'd0);
        check("drain_redirect_pulse", 32'(redirect_valid), 32'd0);
        check("drain_timeout_clear", 32'(drain_timeout), 32'd0);
        check("drain_stall_cycles", stall_cycles, 32'(exp_cycles));

        // INT with the ibus never idle: forced redirect in the 15th drain cycle.
        mem_exccode = EXC_INT;
        mem_pc      = 32'h80006000;
        ibus_idle   = 1'b0;
        settle_stall("to_t0_stall", 6'd0);
        tick();
        mem_exccode = EXC_NONE;
        settle_stall("to_flush_stall", 6'd0);
        check("to_flush", 32'(flush), 32'd1);
        tick();
        for (int k = 1; k <= 15; k++) begin
            settle_stall("to_stall", 6'b000011);
            check("to_redirect", 32'(redirect_valid), 32'(k == 15));
            check("to_sticky_low", 32'(drain_timeout), 32'd0);
            tick();
        end
        settle_stall("to_run_stall", 6'd0);
        check("to_redirect_pulse", 32'(redirect_valid), 32'd0);
        check("to_drain_timeout", 32'(drain_timeout), 32'd1);
        check("to_stall_cycles", stall_cycles, 32'(exp_cycles));
        tick();

        // Reset in the middle of DRAIN while the ibus goes idle: no redirect.
        mem_exccode = EXC_SYS;
        mem_pc      = 32'h80007000;
        settle_stall("rstd_t0_stall", 6'd0);
        tick();
        mem_exccode = EXC_NONE;
        settle_stall("rstd_flush_stall", 6'd0);
        tick();
        for (int k = 1; k <= 2; k++) begin
            settle_stall("rstd_drain_stall", 6'b000011);
            tick();
        end
        rst       = 1'b1;
        ibus_idle = 1'b1;
        settle_stall("rstd_rst_stall", 6'd0);
        check("rstd_rst_redirect", 32'(redirect_valid), 32'd0);
        tick();
        rst = 1'b0;
        settle_stall("rstd_stall", 6'd0);
        check("rstd_redirect", 32'(redirect_valid), 32'd0);
        check("rstd_flush", 32'(flush), 32'd0);
        check("rstd_exc_valid", 32'(exc_valid), 32'd0);
        check("rstd_drain_timeout", 32'(drain_timeout), 32'd0);
        check("rstd_redirect_pc", redirect_pc, 32'd0);
        check("rstd_exc_epc", exc_epc, 32'd0);
        check("rstd_exc_code", 32'(exc_code), 32'(EXC_NONE));
        check("rstd_exc_bd", 32'(exc_bd), 32'd0);
        check("rstd_stall_cycles", stall_cycles, 32'd0);
        tick();
        settle_stall("rstd_after_stall", 6'd0);
        check("rstd_after_redirect", 32'(redirect_valid), 32'd0);
        check("rstd_after_flush", 32'(flush), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
